// File: rtl/satarx_descrambler_if.sv
// AXI-Stream style bundle used for both the scrambled input and descrambled output streams.
// TUSER flags a frame that was truncated because it exceeded the length limit.
interface satarx_descrambler_if;
    logic        TVALID;
    logic        TREADY;
    logic [31:0] TDATA;
    logic        TLAST;
    logic        TUSER;

    modport master (output TVALID, TDATA, TLAST, TUSER, input TREADY);
    modport slave  (input TVALID, TDATA, TLAST, output TREADY);
endinterface

// File: rtl/satarx_descrambler.sv
// SATA receive descrambler: a 16-bit LFSR generates 32 keystream bits per word, and frames
// longer than MAX_WORDS are truncated. Output is fully registered behind a one-entry skid buffer.
module satarx_descrambler #(
    parameter logic [15:0] POLYNOMIAL   = 16'ha011,
    parameter logic [15:0] INITIAL      = 16'hffff,
    parameter int          MAX_WORDS    = 2049,
    parameter bit          OPT_LOWPOWER = 1'b1
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic                i_abort,
    satarx_descrambler_if.slave  S_AXIS,
    satarx_descrambler_if.master M_AXIS,
    output logic                o_overflow
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

    typedef enum logic {PASS, DROP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   fill_q, fill_d, fill_step;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   prn, word;
    logic          accept, push, ovf, out_free, skid_valid_d;

    logic          s_ready_q;
    logic          m_valid_q, m_last_q, m_user_q;
    logic [31:0]   m_data_q;
    logic          skid_valid_q, skid_last_q, skid_user_q;
    logic [31:0]   skid_data_q;
    logic          overflow_q;

    // One full word of keystream: 32 serial LFSR steps unrolled, first bit lands in prn[0].
    always_comb begin : lfsr_word
        logic [15:0] f;
        f   = fill_q;
        prn = '0;
        for (int k = 0; k < 32; k++) begin
            prn[k] = f[15];
            f      = {f[14:0], 1'b0} ^ (f[15] ? POLYNOMIAL : 16'h0000);
        end
        fill_step = f;
    end

    assign accept = S_AXIS.TVALID && s_ready_q;
    assign word   = S_AXIS.TDATA ^ prn;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        count_d = count_q;
        push    = 1'b0;
        ovf     = 1'b0;
        if (accept) begin
            fill_d = S_AXIS.TLAST ? INITIAL : fill_step;
        end
        if (i_abort) begin
            // The beat accepted alongside an abort is dropped, but its TLAST still ends the frame.
            fill_d  = INITIAL;
            count_d = '0;
            state_d = (accept && S_AXIS.TLAST) ? PASS : DROP;
        end else if (accept) begin
            unique case (state_q)
                PASS: begin
                    push = 1'b1;
                    if (S_AXIS.TLAST) begin
                        count_d = '0;
                    end else if (count_q == LAST_IDX) begin
                        ovf     = 1'b1;
                        count_d = '0;
                        state_d = DROP;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                DROP: begin
                    if (S_AXIS.TLAST) begin
                        state_d = PASS;
                        count_d = '0;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= PASS;
            fill_q  <= INITIAL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

    // The skid only ever fills while the output is stalled, so it drains before any new push.
    assign out_free     = !m_valid_q || M_AXIS.TREADY;
    assign skid_valid_d = out_free ? 1'b0 : (skid_valid_q || push);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_user_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            overflow_q   <= ovf;
            skid_valid_q <= skid_valid_d;
            s_ready_q    <= !skid_valid_d;
            if (out_free) begin
                if (skid_valid_q) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= skid_data_q;
                    m_last_q  <= skid_last_q;
                    m_user_q  <= skid_user_q;
                end else if (push) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= word;
                    m_last_q  <= S_AXIS.TLAST || ovf;
                    m_user_q  <= ovf;
                end else begin
                    m_valid_q <= 1'b0;
                    if (OPT_LOWPOWER) begin
                        m_data_q <= '0;
                        m_last_q <= 1'b0;
                        m_user_q <= 1'b0;
                    end
                end
            end else if (push) begin
                skid_data_q <= word;
                skid_last_q <= S_AXIS.TLAST || ovf;
                skid_user_q <= ovf;
            end
        end
    end

    assign S_AXIS.TREADY = s_ready_q;
    assign M_AXIS.TVALID = m_valid_q;
    assign M_AXIS.TDATA  = m_data_q;
    assign M_AXIS.TLAST  = m_last_q;
    assign M_AXIS.TUSER  = m_user_q;
    assign o_overflow    = overflow_q;
endmodule
